// File: rtl/wb_debug_pkg.sv
// Shared constants and state encodings for the UART-driven Wishbone debug master.
// WBDBG_AUTOINC_EN adds the auto-increment command bytes.
package wb_debug_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
`ifdef WBDBG_AUTOINC_EN
   localparam logic [7:0] CMD_WRITE_INC = 8'h77;
   localparam logic [7:0] CMD_READ_INC  = 8'h72;
`endif
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   localparam int ADDR_BYTES = 4;
   localparam int DATA_BYTES = 4;
   localparam logic [2:0] LAST_FIELD_IDX = 3'(ADDR_BYTES - 1);
   localparam logic [2:0] RD_RSP_BYTES   = 3'(DATA_BYTES);
   localparam logic [2:0] ONE_RSP_BYTE   = 3'd1;

   typedef enum logic [2:0] {
      S_IDLE, S_RX_ADDR, S_RX_DATA, S_WB_REQ, S_WB_WAIT, S_TX_BYTE, S_TX_WAIT
   } dbg_state_e;

   typedef enum logic [1:0] {
      P_IDLE, P_REQ, P_WAIT
   } port_state_e;

endpackage

// File: rtl/wbdbg_wb_port.sv
// Single-transaction pipelined Wishbone initiator with stall handling and ack timeout.
// o_done/o_err are combinational in the ack/expiry cycle so the caller can respond on that edge.
module wbdbg_wb_port #(
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [29:0] i_word_addr,
   input  logic [31:0] i_wdata,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_rdata,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_stall,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_data
);
   import wb_debug_pkg::*;

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   port_state_e   r_state;
   logic          r_cyc;
   logic          r_stb;
   logic          r_we;
   logic [29:0]   r_addr;
   logic [31:0]   r_data;
   logic [TW-1:0] r_tmo;

   logic w_accept;
   logic w_ack_ok;
   logic w_expire;

   // An ack seen while the request is still stalled is a slave protocol error and is ignored.
   assign w_accept = (r_state == P_REQ) && !i_wb_stall;
   assign w_ack_ok = i_wb_ack && (w_accept || (r_state == P_WAIT));
   assign w_expire = (r_state == P_WAIT) && !i_wb_ack && (r_tmo == TMO_LAST);

   assign o_done    = w_ack_ok;
   assign o_err     = w_expire;
   assign o_rdata   = i_wb_data;
   assign o_wb_cyc  = r_cyc;
   assign o_wb_stb  = r_stb;
   assign o_wb_we   = r_we;
   assign o_wb_addr = {r_addr, 2'b00};
   assign o_wb_data = r_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= P_IDLE;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_tmo   <= '0;
      end else begin
         case (r_state)
            P_IDLE: begin
               if (i_req) begin
                  r_cyc   <= 1'b1;
                  r_stb   <= 1'b1;
                  r_we    <= i_we;
                  r_addr  <= i_word_addr;
                  r_data  <= i_wdata;
                  r_state <= P_REQ;
               end
            end
            P_REQ: begin
               if (w_accept) begin
                  r_stb <= 1'b0;
                  r_tmo <= '0;
                  if (w_ack_ok) begin
                     r_cyc   <= 1'b0;
                     r_state <= P_IDLE;
                  end else begin
                     r_state <= P_WAIT;
                  end
               end
            end
            P_WAIT: begin
               if (w_ack_ok || w_expire) begin
                  r_cyc   <= 1'b0;
                  r_state <= P_IDLE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            default: r_state <= P_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/wb_debug_master.sv
// UART byte-stream to Wishbone debug master: frame assembly, one bus cycle, byte response.
// Define WBDBG_AUTOINC_EN to enable the 'w'/'r' auto-increment commands.
module wb_debug_master #(
   parameter int ACK_TIMEOUT = 1024,
   parameter int RX_TIMEOUT  = 5000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_byte_rx_data,
   input  logic        i_byte_rx_valid,
   output logic [7:0]  o_byte_tx_data,
   output logic        o_byte_tx_valid,
   input  logic        i_byte_tx_busy,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_stall,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_data,
   output logic        o_busy
);
   import wb_debug_pkg::*;

   localparam int RW = $clog2(RX_TIMEOUT + 1);
   localparam logic [RW-1:0] RX_LAST = RW'(RX_TIMEOUT - 1);

   dbg_state_e    r_state;
   logic [2:0]    r_idx;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [23:0]   r_wdata;
   logic [31:0]   r_shift;
   logic [2:0]    r_tx_cnt;
   logic [7:0]    r_tx_data;
   logic          r_tx_valid;
   logic          r_busy_seen;
   logic [RW-1:0] r_rx_tmo;
`ifdef WBDBG_AUTOINC_EN
   logic [29:0]   r_auto_addr;
`endif

   logic [31:0] w_addr_shift;
   logic [31:0] w_data_shift;
   logic        w_start;
   logic        w_start_we;
   logic [29:0] w_start_addr;
   logic        w_done;
   logic        w_err;
   logic [31:0] w_rdata;
   logic        w_rsp_go;
   logic [31:0] w_rsp_word;
   logic [2:0]  w_rsp_cnt;
   logic        w_in_rx;
   logic        w_rx_expire;

   assign w_in_rx     = (r_state == S_RX_ADDR) || (r_state == S_RX_DATA);
   assign w_rx_expire = (r_rx_tmo == RX_LAST) && !i_byte_rx_valid;

   // The bus request launches on the edge that samples the last frame byte, so address
   // and data are taken from the shifters' next values rather than their registers.
   always_comb begin
      w_addr_shift = {r_addr[23:0], i_byte_rx_data};
      w_data_shift = {r_wdata, i_byte_rx_data};
      w_start      = 1'b0;
      w_start_we   = r_we;
      w_start_addr = r_addr[31:2];
      w_rsp_go     = 1'b0;
      w_rsp_word   = {RSP_NAK, 24'h0};
      w_rsp_cnt    = ONE_RSP_BYTE;
      case (r_state)
         S_IDLE: begin
            if (i_byte_rx_valid) begin
               case (i_byte_rx_data)
                  CMD_WRITE, CMD_READ: ;
`ifdef WBDBG_AUTOINC_EN
                  CMD_WRITE_INC: ;
                  CMD_READ_INC: begin
                     w_start      = 1'b1;
                     w_start_we   = 1'b0;
                     w_start_addr = r_auto_addr;
                  end
`endif
                  default: w_rsp_go = 1'b1;
               endcase
            end
         end
         S_RX_ADDR: begin
            if (i_byte_rx_valid && (r_idx == LAST_FIELD_IDX) && !r_we) begin
               w_start      = 1'b1;
               w_start_addr = w_addr_shift[31:2];
            end
         end
         S_RX_DATA: begin
            if (i_byte_rx_valid && (r_idx == LAST_FIELD_IDX)) w_start = 1'b1;
         end
         S_WB_REQ, S_WB_WAIT: begin
            if (w_done) begin
               w_rsp_go   = 1'b1;
               w_rsp_word = r_we ? {RSP_ACK, 24'h0} : w_rdata;
               w_rsp_cnt  = r_we ? ONE_RSP_BYTE : RD_RSP_BYTES;
            end else if (w_err) begin
               w_rsp_go = 1'b1;
            end
         end
         default: ;
      endcase
   end

   wbdbg_wb_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (w_start),
      .i_we        (w_start_we),
      .i_word_addr (w_start_addr),
      .i_wdata     (w_data_shift),
      .o_done      (w_done),
      .o_err       (w_err),
      .o_rdata     (w_rdata),
      .o_wb_cyc    (o_wb_cyc),
      .o_wb_stb    (o_wb_stb),
      .o_wb_we     (o_wb_we),
      .o_wb_addr   (o_wb_addr),
      .o_wb_data   (o_wb_data),
      .i_wb_stall  (i_wb_stall),
      .i_wb_ack    (i_wb_ack),
      .i_wb_data   (i_wb_data)
   );

   assign o_wb_sel        = 4'hF;
   assign o_byte_tx_data  = r_tx_data;
   assign o_byte_tx_valid = r_tx_valid;
   assign o_busy          = (r_state != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_shift     <= '0;
         r_tx_cnt    <= '0;
         r_tx_data   <= '0;
         r_tx_valid  <= 1'b0;
         r_busy_seen <= 1'b0;
         r_rx_tmo    <= '0;
`ifdef WBDBG_AUTOINC_EN
         r_auto_addr <= '0;
`endif
      end else begin
         r_tx_valid <= 1'b0;
         r_rx_tmo   <= (i_byte_rx_valid || !w_in_rx) ? '0 : r_rx_tmo + RW'(1);
         case (r_state)
            S_IDLE: begin
               if (i_byte_rx_valid) begin
                  r_idx <= '0;
                  case (i_byte_rx_data)
                     CMD_WRITE: begin r_we <= 1'b1; r_state <= S_RX_ADDR; end
                     CMD_READ:  begin r_we <= 1'b0; r_state <= S_RX_ADDR; end
`ifdef WBDBG_AUTOINC_EN
                     CMD_WRITE_INC: begin
                        r_we    <= 1'b1;
                        r_addr  <= {r_auto_addr, 2'b00};
                        r_state <= S_RX_DATA;
                     end
                     CMD_READ_INC: begin
                        r_we    <= 1'b0;
                        r_addr  <= {r_auto_addr, 2'b00};
                        r_state <= S_WB_REQ;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            S_RX_ADDR: begin
               if (i_byte_rx_valid) begin
                  r_addr <= w_addr_shift;
                  r_idx  <= r_idx + 3'd1;
                  if (r_idx == LAST_FIELD_IDX) begin
                     r_idx   <= '0;
                     r_state <= r_we ? S_RX_DATA : S_WB_REQ;
                  end
               end else if (w_rx_expire) begin
                  r_state <= S_IDLE;
               end
            end
            S_RX_DATA: begin
               if (i_byte_rx_valid) begin
                  r_wdata <= w_data_shift[23:0];
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == LAST_FIELD_IDX) r_state <= S_WB_REQ;
               end else if (w_rx_expire) begin
                  r_state <= S_IDLE;
               end
            end
            S_WB_REQ: begin
               if (!i_wb_stall) r_state <= S_WB_WAIT;
            end
            S_WB_WAIT: ;
            S_TX_BYTE: begin
               if (!i_byte_tx_busy) begin
                  r_tx_valid  <= 1'b1;
                  r_tx_data   <= r_shift[31:24];
                  r_shift     <= {r_shift[23:0], 8'h00};
                  r_idx       <= r_idx + 3'd1;
                  r_busy_seen <= 1'b0;
                  r_state     <= S_TX_WAIT;
               end
            end
            S_TX_WAIT: begin
               if (!r_busy_seen) begin
                  if (i_byte_tx_busy) r_busy_seen <= 1'b1;
               end else if (!i_byte_tx_busy) begin
                  r_state <= (r_idx == r_tx_cnt) ? S_IDLE : S_TX_BYTE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Responses start on the deciding edge; if the transmitter is free the first byte goes out now.
         if (w_rsp_go) begin
            r_tx_cnt    <= w_rsp_cnt;
            r_busy_seen <= 1'b0;
            if (!i_byte_tx_busy) begin
               r_tx_valid <= 1'b1;
               r_tx_data  <= w_rsp_word[31:24];
               r_shift    <= {w_rsp_word[23:0], 8'h00};
               r_idx      <= 3'd1;
               r_state    <= S_TX_WAIT;
            end else begin
               r_shift    <= w_rsp_word;
               r_idx      <= '0;
               r_state    <= S_TX_BYTE;
            end
         end
`ifdef WBDBG_AUTOINC_EN
         if (w_done) r_auto_addr <= r_addr[31:2] + 30'd1;
`endif
      end
   end

endmodule

// File: tb/tb_wb_debug_master.sv
// Directed bench for wb_debug_master: scripted Wishbone slave, UART tx sink, byte scoreboard.
// Covers the auto-increment commands when WBDBG_AUTOINC_EN is defined.
module tb_wb_debug_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_busy = 1'b0;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_addr, wb_dat_o;
   logic [3:0]  wb_sel;
   logic        wb_stall = 1'b0;
   logic        wb_ack = 1'b0;
   logic [31:0] wb_dat_i = '0;
   logic        busy;

   wb_debug_master #(.ACK_TIMEOUT(16), .RX_TIMEOUT(100)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_byte_rx_data(rx_data), .i_byte_rx_valid(rx_valid),
      .o_byte_tx_data(tx_data), .o_byte_tx_valid(tx_valid), .i_byte_tx_busy(tx_busy),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
      .o_wb_addr(wb_addr), .o_wb_data(wb_dat_o), .o_wb_sel(wb_sel),
      .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_dat_i),
      .o_busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cycnt = 0;
   always @(posedge clk) cycnt <= cycnt + 1;

   // scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave configuration and observations
   int          stall_left = 0;
   int          ack_delay = 0;
   bit          ack_en = 1'b1;
   logic [31:0] rdata_cfg = '0;
   int          s_wait = 0;
   bit          prev_cyc = 1'b0;
   int          acc_cnt = 0;
   int          stb_cnt = 0;
   int          acc_cyc = 0;
   int          ack_cyc = 0;
   int          drop_cyc = 0;
   logic [31:0] t_addr, t_data;
   logic        t_we;
   logic [3:0]  t_sel;

   always @(negedge clk) begin
      if (rst) begin
         wb_stall = 1'b0;
         wb_ack   = 1'b0;
         s_wait   = 0;
         prev_cyc = 1'b0;
      end else begin
         wb_ack = 1'b0;
         if (wb_cyc && wb_stb) begin
            stb_cnt++;
            if (stall_left > 0) begin
               wb_stall = 1'b1;
               stall_left--;
            end else begin
               wb_stall = 1'b0;
               acc_cnt++;
               acc_cyc = cycnt + 1;
               t_addr = wb_addr; t_data = wb_dat_o; t_we = wb_we; t_sel = wb_sel;
               if (ack_en) begin
                  if (ack_delay == 0) begin
                     wb_ack = 1'b1; wb_dat_i = rdata_cfg; ack_cyc = cycnt + 1;
                  end else begin
                     s_wait = ack_delay;
                  end
               end
            end
         end else begin
            wb_stall = 1'b0;
            if (wb_cyc && s_wait > 0) begin
               s_wait--;
               if (s_wait == 0) begin
                  wb_ack = 1'b1; wb_dat_i = rdata_cfg; ack_cyc = cycnt + 1;
               end
            end
         end
         if (prev_cyc && !wb_cyc) drop_cyc = cycnt;
         prev_cyc = wb_cyc;
      end
   end

   // transmitter sink
   int tx_cyc = -1;
   bit cyc_at_tx = 1'b0;
   int busy_left = 0;

   always @(negedge clk) begin
      if (rst) begin
         tx_busy = 1'b0;
         busy_left = 0;
      end else if (tx_valid) begin
         got_q.push_back(tx_data);
         if (tx_cyc < 0) begin
            tx_cyc = cycnt;
            cyc_at_tx = wb_cyc;
         end
         tx_busy = 1'b1;
         busy_left = 2;
      end else if (busy_left > 0) begin
         busy_left--;
      end else begin
         tx_busy = 1'b0;
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_idle"}, busy, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_tx(input string tag);
      check_eq({tag, "_ntx"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0)
         check_eq({tag, "_tx"}, got_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      got_q.delete();
      tx_cyc = -1;
   endtask

   int t0;
   int acc0;

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_cyc", wb_cyc, 1'b0);
      check_eq("rst_stb", wb_stb, 1'b0);
      check_eq("rst_txv", tx_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_sel", wb_sel, 4'hF);
      check_eq("rst_addr", wb_addr, 32'h0);
      rst = 1'b0;

      // write, ack two cycles after accept
      ack_delay = 2; stall_left = 0; ack_en = 1'b1;
      send_byte(8'h57); send_word(32'h0000_0010); send_word(32'hDEAD_BEEF);
      check_eq("wr_cyc_start", wb_cyc, 1'b1);
      check_eq("wr_stb_start", wb_stb, 1'b1);
      exp_q.push_back(8'h06);
      wait_idle("wr");
      check_eq("wr_addr", t_addr, 32'h10);
      check_eq("wr_data", t_data, 32'hDEADBEEF);
      check_eq("wr_we", t_we, 1'b1);
      check_eq("wr_sel", t_sel, 4'hF);
      check_eq("wr_acc", acc_cnt, 1);
      check_eq("wr_ack_to_tx", tx_cyc, ack_cyc);
      check_eq("wr_cyc_at_tx", cyc_at_tx, 1'b0);
      check_tx("wr");

      // read with three stall cycles
      stall_left = 3; ack_delay = 1; rdata_cfg = 32'h1234_5678; stb_cnt = 0;
      send_byte(8'h52); send_word(32'h0080_0004);
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      exp_q.push_back(8'h56); exp_q.push_back(8'h78);
      wait_idle("rd");
      check_eq("rd_addr", t_addr, 32'h0080_0004);
      check_eq("rd_we", t_we, 1'b0);
      check_eq("rd_stb_cycles", stb_cnt, 4);
      check_tx("rd");

      // ack timeout
      ack_en = 1'b0;
      send_byte(8'h52); send_word(32'h0000_0100);
      exp_q.push_back(8'h15);
      wait_idle("tmo");
      check_eq("tmo_drop_lat", drop_cyc - acc_cyc, 16);
      check_tx("tmo");
      ack_en = 1'b1;

      // partial frame then silence
      send_byte(8'h52); send_byte(8'h00);
      t0 = cycnt;
      repeat (50) @(negedge clk);
      check_eq("rxt_busy_mid", busy, 1'b1);
      while (busy && (cycnt - t0) < 300) @(negedge clk);
      check_eq("rxt_lat", cycnt - t0, 100);
      check_eq("rxt_no_tx", got_q.size(), 0);

      // full frame afterwards, ack in the accept cycle
      ack_delay = 0;
      send_byte(8'h57); send_word(32'h0000_0040); send_word(32'h0102_0304);
      exp_q.push_back(8'h06);
      wait_idle("wr0");
      check_eq("wr0_addr", t_addr, 32'h40);
      check_eq("wr0_data", t_data, 32'h0102_0304);
      check_eq("wr0_ack_to_tx", tx_cyc, ack_cyc);
      check_tx("wr0");

      // unknown command
      acc0 = acc_cnt;
      send_byte(8'h41);
      exp_q.push_back(8'h15);
      wait_idle("unk");
      check_eq("unk_no_bus", acc_cnt, acc0);
      check_tx("unk");

      // reset while waiting for ack
      ack_en = 1'b0;
      send_byte(8'h52); send_word(32'h0000_0200);
      repeat (3) @(negedge clk);
      check_eq("rstw_cyc_pre", wb_cyc, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rstw_cyc", wb_cyc, 1'b0);
      check_eq("rstw_stb", wb_stb, 1'b0);
      check_eq("rstw_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("rstw_no_tx", got_q.size(), 0);
      ack_en = 1'b1; ack_delay = 1;

`ifdef WBDBG_AUTOINC_EN
      send_byte(8'h57); send_word(32'h0000_0020); send_word(32'h1122_3344);
      exp_q.push_back(8'h06);
      wait_idle("ai_w0");
      check_eq("ai_w0_addr", t_addr, 32'h20);
      check_tx("ai_w0");
      send_byte(8'h77); send_word(32'hAABB_CCDD);
      exp_q.push_back(8'h06);
      wait_idle("ai_w1");
      check_eq("ai_w1_addr", t_addr, 32'h24);
      check_eq("ai_w1_data", t_data, 32'hAABB_CCDD);
      check_tx("ai_w1");
      rdata_cfg = 32'hCAFE_F00D;
      send_byte(8'h72);
      exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
      exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
      wait_idle("ai_r");
      check_eq("ai_r_addr", t_addr, 32'h28);
      check_eq("ai_r_we", t_we, 1'b0);
      check_tx("ai_r");
`else
      acc0 = acc_cnt;
      send_byte(8'h77);
      exp_q.push_back(8'h15);
      wait_idle("noai");
      check_eq("noai_no_bus", acc_cnt, acc0);
      check_tx("noai");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
